pc_fetch_unit: RTL and testbench

- Sequential next-PC and instruction-fetch front end for the exp11 RISC-V core.
- Consumes the branch-decision pair PCAsrc/PCBsrc plus the immediate and rs1 from execute, and owns the PC register.
- Issues one-outstanding fetches to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents fetched instructions to decode with a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/next_pc_adder.sv | 38 +++
 rtl/pc_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-state, PC increment and branch-encoding definitions
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

endpackage

// File: rtl/next_pc_adder.sv
// rtl/next_pc_adder.sv - combinational redirect target with JALR bit0 clear and misalign detect
module next_pc_adder
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit ALIGN_TRAP = 1'b0
) (
    input  logic            pca_src,
    input  logic            pcb_src,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offs;
    logic [XLEN-1:0] sum;

    // Select operands, add modulo 2^XLEN; without trapping, low bits are forced to word alignment
    always_comb begin
        base = pcb_src ? rs1 : br_pc;
        offs = pca_src ? imm : XLEN'(PC_INC);
        sum  = base + offs;
        if (pcb_src) begin
            sum[0] = 1'b0;
        end
        if (ALIGN_TRAP) begin
            target   = sum;
            misalign = |sum[1:0];
        end else begin
            target   = {sum[XLEN-1:2], 2'b00};
            misalign = 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, one-outstanding fetch FSM and decode buffer (option: FETCH_MISALIGN_TRAP_EN)
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    input  logic            pca_src,
    input  logic            pcb_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            fetch_misalign,
`endif
    output logic [XLEN-1:0] instr_pc
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            instr_valid_q, instr_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            target_misalign;

    assign redirect = br_valid & (pca_src | pcb_src);

    next_pc_adder #(
        .XLEN       (XLEN),
        .ALIGN_TRAP (TRAP_EN)
    ) u_next_pc_adder (
        .pca_src  (pca_src),
        .pcb_src  (pcb_src),
        .br_pc    (br_pc),
        .imm      (imm),
        .rs1      (rs1),
        .target   (target),
        .misalign (target_misalign)
    );

    // Next-state, PC and instruction-buffer update; redirects override the normal flow
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_req_ready) begin
                    // a request accepted alongside a redirect carries the stale pc
                    kill_d  = redirect;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d = target;
                    if (imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + XLEN'(PC_INC);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = TRAP;
            end
        endcase
        // misaligned target is only possible when trapping is built in
        if (redirect && target_misalign && (state_q != TRAP)) begin
            pc_d    = target;
            kill_d  = 1'b0;
            state_d = TRAP;
        end
        instr_valid_d = (state_d == HOLD);
    end

    // State, PC and decode-buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imem_req_valid = rst_n & (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit (option: FETCH_MISALIGN_TRAP_EN)
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        pca_src;
    logic        pcb_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_pc          (br_pc),
        .pca_src        (pca_src),
        .pcb_src        (pcb_src),
        .imm            (imm),
        .rs1            (rs1),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic a, input logic b, input logic [31:0] bpc,
                          input logic [31:0] im, input logic [31:0] r1);
        br_valid = 1'b1;
        pca_src  = a;
        pcb_src  = b;
        br_pc    = bpc;
        imm      = im;
        rs1      = r1;
    endtask

    task automatic clr_br();
        br_valid = 1'b0;
        pca_src  = 1'b0;
        pcb_src  = 1'b0;
    endtask

    // starts in FETCH at address a; ends in FETCH at a+4
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        check_eq("req_valid", {63'd0, imem_req_valid}, 64'd1);
        check_eq("req_addr", {32'd0, imem_addr}, {32'd0, a});
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check_eq("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
        check_eq("wait_no_valid", {63'd0, instr_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rdata     = d;
        tick();
        imem_rsp_valid = 1'b0;
        check_eq("hold_valid", {63'd0, instr_valid}, 64'd1);
        check_eq("hold_instr", {32'd0, instr}, {32'd0, d});
        check_eq("hold_pc", {32'd0, instr_pc}, {32'd0, a});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("post_valid", {63'd0, instr_valid}, 64'd0);
        check_eq("next_addr", {32'd0, imem_addr}, {32'd0, a + 32'd4});
    endtask

    initial begin
        rst_n          = 1'b0;
        clr_br();
        br_pc          = '0;
        imm            = '0;
        rs1            = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;

        tick();
        tick();
        check_eq("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check_eq("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        check_eq("rst_instr", {32'd0, instr}, 64'd0);
        check_eq("rst_instr_pc", {32'd0, instr_pc}, 64'd0);
        check_eq("rst_addr", {32'd0, imem_addr}, 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("rst_misalign", {63'd0, fetch_misalign}, 64'd0);
`endif
        rst_n = 1'b1;
        #1;

        // sequential fetch
        fetch_one(32'h0, 32'hA000_0000);
        fetch_one(32'h4, 32'hA000_0004);
        fetch_one(32'h8, 32'hA000_0008);

        // decode back-pressure at 0xC
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hA000_000C;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {63'd0, instr_valid}, 64'd1);
            check_eq("bp_instr", {32'd0, instr}, 64'h0000_0000_A000_000C);
            check_eq("bp_pc", {32'd0, instr_pc}, 64'hC);
            check_eq("bp_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("bp_advance", {32'd0, imem_addr}, 64'h10);

        // memory back-pressure holds the address
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mem_bp_valid", {63'd0, imem_req_valid}, 64'd1);
            check_eq("mem_bp_addr", {32'd0, imem_addr}, 64'h10);
        end

        // JAL redirect in HOLD with simultaneous instr_ready
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hA000_0010;
        tick();
        imem_rsp_valid = 1'b0;
        check_eq("jal_hold_valid", {63'd0, instr_valid}, 64'd1);
        set_br(1'b1, 1'b0, 32'h100, 32'h40, 32'h0);
        instr_ready = 1'b1;
        tick();
        clr_br();
        instr_ready = 1'b0;
        check_eq("jal_squash", {63'd0, instr_valid}, 64'd0);
        check_eq("jal_addr", {32'd0, imem_addr}, 64'h140);
        fetch_one(32'h140, 32'hB000_0140);

        // JALR redirect in WAIT: in-flight response discarded
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        set_br(1'b1, 1'b1, 32'h144, 32'h10, 32'h2001);
        tick();
        clr_br();
        check_eq("jalr_wait_no_req", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_0144;
        tick();
        imem_rsp_valid = 1'b0;
        check_eq("jalr_killed", {63'd0, instr_valid}, 64'd0);
        check_eq("jalr_addr", {32'd0, imem_addr}, 64'h2010);
        fetch_one(32'h2010, 32'hC000_2010);

        // redirect in WAIT coincident with the response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        set_br(1'b1, 1'b0, 32'h300, 32'h20, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_2014;
        tick();
        clr_br();
        imem_rsp_valid = 1'b0;
        check_eq("coin_no_valid", {63'd0, instr_valid}, 64'd0);
        check_eq("coin_req", {63'd0, imem_req_valid}, 64'd1);
        check_eq("coin_addr", {32'd0, imem_addr}, 64'h320);
        fetch_one(32'h320, 32'hD000_0320);

        // redirect in FETCH while request handshakes: old pc goes out, response killed
        check_eq("fr_old_addr", {32'd0, imem_addr}, 64'h324);
        set_br(1'b0, 1'b1, 32'h0, 32'h0, 32'h500);
        imem_req_ready = 1'b1;
        tick();
        clr_br();
        imem_req_ready = 1'b0;
        check_eq("fr_wait", {63'd0, imem_req_valid}, 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_0324;
        tick();
        imem_rsp_valid = 1'b0;
        check_eq("fr_killed", {63'd0, instr_valid}, 64'd0);
        check_eq("fr_addr", {32'd0, imem_addr}, 64'h504);
        fetch_one(32'h504, 32'hE000_0504);

        // fall-through br_valid has no effect
        set_br(1'b0, 1'b0, 32'h900, 32'h80, 32'h700);
        tick();
        clr_br();
        check_eq("ft_addr", {32'd0, imem_addr}, 64'h508);

        // wrap modulo 2^32 while sitting in FETCH
        set_br(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
        tick();
        clr_br();
        check_eq("wrap_addr", {32'd0, imem_addr}, 64'h10);

        // stray response in FETCH is ignored
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hBAD0_BAD0;
        tick();
        imem_rsp_valid = 1'b0;
        check_eq("stray_no_valid", {63'd0, instr_valid}, 64'd0);
        check_eq("stray_addr", {32'd0, imem_addr}, 64'h10);

        // misaligned redirect target 0x102
        set_br(1'b1, 1'b0, 32'h100, 32'h2, 32'h0);
        tick();
        clr_br();
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            check_eq("trap_flag", {63'd0, fetch_misalign}, 64'd1);
            check_eq("trap_no_req", {63'd0, imem_req_valid}, 64'd0);
            check_eq("trap_no_valid", {63'd0, instr_valid}, 64'd0);
            imem_req_ready = 1'b1;
            tick();
            imem_req_ready = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("trap_rst_flag", {63'd0, fetch_misalign}, 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("trap_rst_addr", {32'd0, imem_addr}, 64'h0);
        check_eq("trap_rst_req", {63'd0, imem_req_valid}, 64'd1);
`else
        check_eq("align_addr", {32'd0, imem_addr}, 64'h100);
        fetch_one(32'h100, 32'hF000_0100);
`endif

        // reset asserted mid-WAIT; late response afterwards is ignored
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check_eq("mw_in_wait", {63'd0, imem_req_valid}, 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mw_rst_req", {63'd0, imem_req_valid}, 64'd0);
        tick();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hBAD1_BAD1;
        tick();
        imem_rsp_valid = 1'b0;
        check_eq("mw_late_ignored", {63'd0, instr_valid}, 64'd0);
        check_eq("mw_addr", {32'd0, imem_addr}, 64'h0);
        check_eq("mw_req", {63'd0, imem_req_valid}, 64'd1);
        fetch_one(32'h0, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
